// File: rtl/seq_frame_arb.sv
// Round-robin N-requester packet framer with MARKER-delimited frames.
// Option: SEQ_FRAME_MAXW_EN caps payload words per frame at MAXW.
module seq_frame_arb #(
  parameter int w    = 128,
  parameter int N    = 4,
  parameter int MAXW = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [0:N*w-1] req_data,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [w-1:0]   odata,
  output logic           ovalid,
  input  logic           oready,
  output logic [N-1:0]   grant,
  output logic           perr
);

  localparam int PW = $clog2(N);
  localparam int QW = w / 4;

  typedef enum logic [1:0] {
    IDLE,
    SOP,
    DATA,
    EOP
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gi;
  logic [PW-1:0] sel;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  logic [w-1:0]  word;
  logic          mark;
  logic          hs;
  logic          fin;

  // first valid requester at or after the pointer, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + k) % N);
      end
    end
  end

  // owner index from the one-hot grant
  always_comb begin
    gi = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gi = PW'(i);
    end
  end

  // owner's word and whether any quarter looks like a marker
  always_comb begin
    word = req_data[int'(gi)*w +: w];
    mark = 1'b0;
    for (int q = 0; q < 4; q++) begin
      if (word[q*QW +: QW] == {QW{1'b1}}) mark = 1'b1;
    end
  end

  assign hs      = (state == DATA) && req_valid[gi] && oready;
  assign ptr_nxt = (gi == PW'(N-1)) ? '0 : gi + 1'b1;

`ifdef SEQ_FRAME_MAXW_EN
  localparam int CW = $clog2(MAXW + 1);
  logic [CW-1:0] cnt;
  assign fin = hs & (req_last[gi] | (~mark & (cnt == CW'(MAXW - 1))));
`else
  logic unused_maxw;
  assign unused_maxw = ^MAXW;
  assign fin = hs & req_last[gi];
`endif

  // outputs decoded from state and the owner's inputs
  always_comb begin
    odata     = '0;
    ovalid    = 1'b0;
    req_ready = '0;
    perr      = 1'b0;
    unique case (state)
      IDLE: ;
      SOP, EOP: begin
        odata  = '1;
        ovalid = 1'b1;
      end
      DATA: begin
        req_ready[gi] = oready;
        odata         = word;
        ovalid        = req_valid[gi] & ~mark;
        perr          = req_valid[gi] & oready & mark;
      end
      default: ;
    endcase
  end

  // frame FSM: arbitrate, open, forward, close
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
`ifdef SEQ_FRAME_MAXW_EN
      cnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= {{(N-1){1'b0}}, 1'b1} << sel;
            state <= SOP;
`ifdef SEQ_FRAME_MAXW_EN
            cnt   <= '0;
`endif
          end
        end
        SOP: begin
          if (oready) state <= DATA;
        end
        DATA: begin
`ifdef SEQ_FRAME_MAXW_EN
          if (hs && !mark) cnt <= fin ? '0 : cnt + 1'b1;
`endif
          if (fin) state <= EOP;
        end
        EOP: begin
          if (oready) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= ptr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_arb.sv
// Scoreboard bench for seq_frame_arb: framing, arbitration, stalls,
// marker drops, optional word cap and reset abandonment.
module tb_seq_frame_arb;

  localparam int W    = 128;
  localparam int N    = 4;
  localparam int MAXW = 4;
`ifdef SEQ_FRAME_MAXW_EN
  localparam int LIM = MAXW;
`else
  localparam int LIM = 0;
`endif
  localparam logic [W-1:0] MK = '1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [0:N*W-1] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   odata;
  logic           ovalid;
  logic           oready;
  logic [N-1:0]   grant;
  logic           perr;

  always #5 clock = ~clock;

  seq_frame_arb #(.w(W), .N(N), .MAXW(MAXW)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_ready(req_ready),
    .odata    (odata),
    .ovalid   (ovalid),
    .oready   (oready),
    .grant    (grant),
    .perr     (perr)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } wd_t;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] g;
  } ex_t;

  wd_t rq[N][$];
  ex_t expq[$];
  ex_t e;
  int  checks   = 0;
  int  failures = 0;
  int  perr_cnt = 0;
  int  p0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] gr(input int r);
    logic [N-1:0] one = 1;
    return one << r;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pkt(input int r, input int n, input logic [W-1:0] base);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      wd_t x;
      x.d = base + W'(k);
      x.l = (k == n - 1);
      rq[r].push_back(x);
      if (c == 0) expq.push_back(ex_t'{MK, gr(r)});
      expq.push_back(ex_t'{x.d, gr(r)});
      c++;
      if (k == n - 1 || (LIM > 0 && c == LIM)) begin
        expq.push_back(ex_t'{MK, gr(r)});
        c = 0;
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((expq.size() != 0 || grant != '0 || pending()) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_q"}, W'(expq.size()), '0);
    check({tag, "_idle"}, W'(grant), '0);
  endtask

  task automatic wait_ov(input string tag);
    int n = 0;
    @(negedge clock);
    while (!ovalid && n < 30) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ov_to"}, W'(ovalid), W'(1));
  endtask

  // requester model: present queue heads, retire on handshake
  initial begin : drv
    logic [N-1:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*W +: W]   = rq[i][0].d;
          req_last[i]          = rq[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // output monitor against the scoreboard
  always @(negedge clock) begin
    if (reset) begin
      if (perr) begin
        perr_cnt++;
        check("perr_ovalid", W'(ovalid), '0);
      end
      if (ovalid && oready) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", W'(expq.size()), W'(1));
        end else begin
          e = expq.pop_front();
          check("beat_data", odata, e.d);
          check("beat_grant", W'(grant), W'(e.g));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    oready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ovalid", W'(ovalid), '0);
    check("rst_ready", W'(req_ready), '0);
    check("rst_grant", W'(grant), '0);
    check("rst_odata", odata, '0);
    check("rst_perr", W'(perr), '0);
    @(posedge clock);
    #1 reset = 1'b1;

    // basic 3-word frame, back-to-back beats
    pkt(0, 3, W'('h100));
    wait_ov("t032");
    for (int k = 0; k < 5; k++) begin
      check("t032_ov", W'(ovalid), W'(1));
      check("t032_g", W'(grant), W'(4'b0001));
      if (k < 4) @(negedge clock);
    end
    drain("t032");

    // simultaneous requests after reset, then wrap to 0
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    pkt(1, 1, W'('h200));
    pkt(3, 1, W'('h300));
    drain("t033");
    pkt(0, 1, W'('h500));
    pkt(2, 1, W'('h600));
    drain("t033w");

    // back-pressure in SOP and mid-DATA
    oready = 1'b0;
    pkt(2, 4, W'('h700));
    wait_ov("t034");
    check("t034_sop", odata, MK);
    repeat (2) begin
      @(negedge clock);
      check("t034_sop_hold", odata, MK);
      check("t034_sop_rdy", W'(req_ready), '0);
    end
    @(posedge clock);
    #1 oready = 1'b1;
    repeat (2) @(posedge clock);
    #1 oready = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("t034_dat_hold", odata, W'('h701));
      check("t034_dat_ov", W'(ovalid), W'(1));
      check("t034_dat_rdy", W'(req_ready), '0);
    end
    @(posedge clock);
    #1 oready = 1'b1;
    drain("t034");

    // marker-quarter words dropped with perr
    p0 = perr_cnt;
    rq[1].push_back(wd_t'{W'('h800), 1'b0});
    rq[1].push_back(wd_t'{{96'h0, 32'hFFFF_FFFF}, 1'b0});
    rq[1].push_back(wd_t'{W'('h802), 1'b1});
    expq.push_back(ex_t'{MK, gr(1)});
    expq.push_back(ex_t'{W'('h800), gr(1)});
    expq.push_back(ex_t'{W'('h802), gr(1)});
    expq.push_back(ex_t'{MK, gr(1)});
    drain("t035");
    check("t035_perr", W'(perr_cnt - p0), W'(1));
    rq[3].push_back(wd_t'{W'('h900), 1'b0});
    rq[3].push_back(wd_t'{{32'hFFFF_FFFF, 96'h0}, 1'b1});
    expq.push_back(ex_t'{MK, gr(3)});
    expq.push_back(ex_t'{W'('h900), gr(3)});
    expq.push_back(ex_t'{MK, gr(3)});
    drain("t035l");
    check("t035l_perr", W'(perr_cnt - p0), W'(2));

    // long packet: split by the cap when enabled
    p0 = perr_cnt;
    pkt(0, 6, W'('hA00));
    drain("t036");
    check("t036_perr", W'(perr_cnt - p0), '0);

    // reset in DATA abandons the frame
    pkt(2, 5, W'('hB00));
    wait_ov("t036r");
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("t036r_ov", W'(ovalid), '0);
    check("t036r_grant", W'(grant), '0);
    check("t036r_rdy", W'(req_ready), '0);
    check("t036r_odata", odata, '0);
    rq[2].delete();
    expq.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("t036r_noeop", W'(ovalid), '0);
    end

    // first arbitration after reset starts at requester 0
    pkt(0, 1, W'('hC10));
    pkt(2, 1, W'('hC00));
    drain("t029");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
